// File: rtl/c3po_dispatch_if.sv
// Input beat bus of c3po_dispatch.
// A beat is consumed on the cycle val & in_ready are both high.
interface c3po_dispatch_if #(
    parameter int IN_BYTES_P = 160
);
    localparam int VW = $clog2(IN_BYTES_P + 1);

    logic                    val;
    logic                    sop;
    logic                    eop;
    logic [3:0]              id;
    logic [VW-1:0]           vbc;
    logic [IN_BYTES_P*8-1:0] data;
    logic                    in_ready;

    modport master (
        output val, sop, eop, id, vbc, data,
        input  in_ready
    );

    modport slave (
        input  val, sop, eop, id, vbc, data,
        output in_ready
    );
endinterface

// File: rtl/c3po_dispatch.sv
// Wide-beat dispatcher: routes beats to output ports by id,
// slices each into narrow chunks and keeps per-port statistics.
module c3po_dispatch #(
    parameter int PORTS_P     = 4,
    parameter int IN_BYTES_P  = 160,
    parameter int OUT_BYTES_P = 32,
    parameter int CNT_W_P     = 16,
    localparam int VW  = $clog2(IN_BYTES_P + 1),
    localparam int OVW = $clog2(OUT_BYTES_P + 1)
) (
    input  logic                             clk,
    input  logic                             reset_L,
    c3po_dispatch_if.slave                   in_if,
    input  logic [PORTS_P*4-1:0]             cfg_port_id,
    input  logic [PORTS_P-1:0]               cfg_port_enable,
    input  logic                             cfg_bcast_en,
    input  logic [3:0]                       cfg_bcast_id,
    input  logic [PORTS_P-1:0]               cnt_clr,
    output logic [PORTS_P-1:0]               o_val,
    output logic [PORTS_P-1:0]               o_sop,
    output logic [PORTS_P-1:0]               o_eop,
    output logic [PORTS_P*OVW-1:0]           o_vbc,
    output logic [PORTS_P*OUT_BYTES_P*8-1:0] o_data,
    output logic [PORTS_P-1:0]               ready,
    output logic [PORTS_P*CNT_W_P-1:0]       pkt_cnt,
    output logic [PORTS_P*CNT_W_P-1:0]       byte_cnt,
    output logic [PORTS_P*CNT_W_P-1:0]       err_cnt
);
    localparam int OW = OUT_BYTES_P * 8;
    localparam int IW = IN_BYTES_P * 8;
    localparam int SW = (CNT_W_P > VW ? CNT_W_P : VW) + 1;
    localparam logic [CNT_W_P-1:0] CMAX = {CNT_W_P{1'b1}};
    localparam logic [VW-1:0] OB = VW'(OUT_BYTES_P);
    localparam logic [VW-1:0] IB = VW'(IN_BYTES_P);

    typedef enum logic [1:0] {
        IDLE,
        PKT,
        DROP
    } state_e;

    logic               bc_hit;
    logic               vbc_ok;
    logic               fire;
    logic [PORTS_P-1:0] dlv;

    function automatic logic [CNT_W_P-1:0] sat_add(
        input logic [CNT_W_P-1:0] c,
        input logic [SW-1:0]      a
    );
        logic [SW-1:0] s;
        s = SW'(c) + a;
        return (s > SW'(CMAX)) ? CMAX : s[CNT_W_P-1:0];
    endfunction

    assign bc_hit = cfg_bcast_en && (in_if.id == cfg_bcast_id);
    assign vbc_ok = (in_if.vbc != '0) && (in_if.vbc <= IB);

    // Only ports that will actually store the beat can stall it.
    assign in_if.in_ready = &(~dlv | ready);
    assign fire           = in_if.val && in_if.in_ready;

    for (genvar i = 0; i < PORTS_P; i++) begin : g_port
        state_e             state_q;
        state_e             state_d;
        logic               tgt;
        logic               deliver;
        logic               err;
        logic               busy_q;
        logic               sop_q;
        logic               eop_q;
        logic               first_q;
        logic               last;
        logic [VW-1:0]      rem_q;
        logic [IW-1:0]      hold_q;
        logic [CNT_W_P-1:0] pkt_q;
        logic [CNT_W_P-1:0] byte_q;
        logic [CNT_W_P-1:0] err_q;

        assign tgt = bc_hit || (cfg_port_id[i*4 +: 4] == in_if.id);

        always_comb begin
            state_d = state_q;
            deliver = 1'b0;
            err     = 1'b0;
            if (tgt) begin
                if (!vbc_ok) begin
                    err = 1'b1;
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            if (!in_if.sop) begin
                                err = 1'b1;
                            end else begin
                                deliver = cfg_port_enable[i];
                                if (!in_if.eop) begin
                                    state_d = cfg_port_enable[i] ? PKT : DROP;
                                end
                            end
                        end
                        PKT: begin
                            if (in_if.sop) begin
                                err = 1'b1;
                            end else begin
                                deliver = 1'b1;
                                if (in_if.eop) state_d = IDLE;
                            end
                        end
                        DROP: begin
                            if (in_if.eop) state_d = IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end

        assign dlv[i] = deliver;
        assign last   = rem_q <= OB;

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
                first_q <= 1'b0;
                rem_q   <= '0;
                hold_q  <= '0;
            end else begin
                if (fire) state_q <= state_d;
                if (fire && deliver) begin
                    busy_q  <= 1'b1;
                    sop_q   <= in_if.sop;
                    eop_q   <= in_if.eop;
                    first_q <= 1'b1;
                    rem_q   <= in_if.vbc;
                    hold_q  <= in_if.data;
                end else if (busy_q) begin
                    // Shift so the current chunk always sits at the LSBs.
                    first_q <= 1'b0;
                    rem_q   <= rem_q - OB;
                    hold_q  <= hold_q >> OW;
                    if (last) busy_q <= 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                pkt_q  <= '0;
                byte_q <= '0;
                err_q  <= '0;
            end else if (cnt_clr[i]) begin
                pkt_q  <= '0;
                byte_q <= '0;
                err_q  <= '0;
            end else if (fire) begin
                if (deliver) begin
                    byte_q <= sat_add(byte_q, SW'(in_if.vbc));
                    if (in_if.eop) pkt_q <= sat_add(pkt_q, SW'(1));
                end
                if (err) err_q <= sat_add(err_q, SW'(1));
            end
        end

        assign ready[i] = ~busy_q;
        assign o_val[i] = busy_q;
        assign o_sop[i] = busy_q && sop_q && first_q;
        assign o_eop[i] = busy_q && eop_q && last;

        assign o_vbc[i*OVW +: OVW] = !busy_q ? '0 :
                                     last    ? OVW'(rem_q) :
                                               OVW'(OUT_BYTES_P);

        assign o_data[i*OW +: OW]        = hold_q[OW-1:0];
        assign pkt_cnt[i*CNT_W_P +: CNT_W_P]  = pkt_q;
        assign byte_cnt[i*CNT_W_P +: CNT_W_P] = byte_q;
        assign err_cnt[i*CNT_W_P +: CNT_W_P]  = err_q;
    end
endmodule

// File: tb/tb_c3po_dispatch.sv
// Bench for c3po_dispatch: chunk-queue reference model checked every
// cycle, plus hand-computed expectations and a narrow-counter instance.
module tb_c3po_dispatch;
    localparam int P   = 4;
    localparam int IB  = 160;
    localparam int OB  = 32;
    localparam int CW  = 16;
    localparam int VW  = 8;
    localparam int OVW = 6;
    localparam int OW  = OB * 8;
    localparam longint CMAXL = 65535;
    localparam int M_IDLE = 0;
    localparam int M_PKT  = 1;
    localparam int M_DROP = 2;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    c3po_dispatch_if #(.IN_BYTES_P(IB)) bus ();
    c3po_dispatch_if #(.IN_BYTES_P(IB)) sbus ();

    logic [P*4-1:0]   cfg_port_id;
    logic [P-1:0]     cfg_port_enable;
    logic             cfg_bcast_en;
    logic [3:0]       cfg_bcast_id;
    logic [P-1:0]     cnt_clr;
    logic [P-1:0]     o_val, o_sop, o_eop, ready;
    logic [P*OVW-1:0] o_vbc;
    logic [P*OW-1:0]  o_data;
    logic [P*CW-1:0]  pkt_cnt, byte_cnt, err_cnt;

    logic             s_clr;
    logic             s_val, s_sop, s_eop, s_rdy;
    logic [OVW-1:0]   s_vbc;
    logic [OW-1:0]    s_data;
    logic [3:0]       s_pkt, s_byte, s_err;

    c3po_dispatch #(
        .PORTS_P(P), .IN_BYTES_P(IB), .OUT_BYTES_P(OB), .CNT_W_P(CW)
    ) dut (
        .clk(clk), .reset_L(reset_L), .in_if(bus),
        .cfg_port_id(cfg_port_id), .cfg_port_enable(cfg_port_enable),
        .cfg_bcast_en(cfg_bcast_en), .cfg_bcast_id(cfg_bcast_id),
        .cnt_clr(cnt_clr), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop),
        .o_vbc(o_vbc), .o_data(o_data), .ready(ready),
        .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .err_cnt(err_cnt)
    );

    c3po_dispatch #(
        .PORTS_P(1), .IN_BYTES_P(IB), .OUT_BYTES_P(OB), .CNT_W_P(4)
    ) dut_s (
        .clk(clk), .reset_L(reset_L), .in_if(sbus),
        .cfg_port_id(4'h0), .cfg_port_enable(1'b1),
        .cfg_bcast_en(1'b0), .cfg_bcast_id(4'hF),
        .cnt_clr(s_clr), .o_val(s_val), .o_sop(s_sop), .o_eop(s_eop),
        .o_vbc(s_vbc), .o_data(s_data), .ready(s_rdy),
        .pkt_cnt(s_pkt), .byte_cnt(s_byte), .err_cnt(s_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic longint msat(input longint a);
        return (a > CMAXL) ? CMAXL : a;
    endfunction

    typedef struct {
        logic [OW-1:0] d;
        int            vbc;
        bit            sop;
        bit            eop;
    } chunk_t;

    chunk_t mq [P][$];
    int     mst [P];
    longint mpk [P];
    longint mby [P];
    longint mer [P];
    int     mact [P];
    int     mnst [P];
    chunk_t mc;
    bit     mrdy;
    bit     mtgt;
    int     mv;
    int     mn;

    // Reference model: a queue of expected chunks per port.
    always @(negedge clk) begin
        if (!reset_L) begin
            for (int i = 0; i < P; i++) begin
                mq[i].delete();
                mst[i] = M_IDLE;
                mpk[i] = 0;
                mby[i] = 0;
                mer[i] = 0;
            end
        end
        for (int i = 0; i < P; i++) begin
            if (mq[i].size() != 0) begin
                mc = mq[i][0];
                chk($sformatf("o_val[%0d]", i), o_val[i], 1'b1);
                chk($sformatf("o_vbc[%0d]", i), o_vbc[i*OVW +: OVW], mc.vbc);
                chk($sformatf("o_sop[%0d]", i), o_sop[i], mc.sop);
                chk($sformatf("o_eop[%0d]", i), o_eop[i], mc.eop);
                chk($sformatf("o_data[%0d]", i), o_data[i*OW +: OW], mc.d);
            end else begin
                chk($sformatf("o_val[%0d]", i), o_val[i], 1'b0);
                chk($sformatf("o_vbc[%0d]", i), o_vbc[i*OVW +: OVW], 0);
                chk($sformatf("o_sop[%0d]", i), o_sop[i], 1'b0);
                chk($sformatf("o_eop[%0d]", i), o_eop[i], 1'b0);
            end
            chk($sformatf("ready[%0d]", i), ready[i], mq[i].size() == 0);
            chk($sformatf("pkt_cnt[%0d]", i), pkt_cnt[i*CW +: CW], mpk[i]);
            chk($sformatf("byte_cnt[%0d]", i), byte_cnt[i*CW +: CW], mby[i]);
            chk($sformatf("err_cnt[%0d]", i), err_cnt[i*CW +: CW], mer[i]);
        end
        mrdy = 1'b1;
        mv = int'(bus.vbc);
        for (int i = 0; i < P; i++) begin
            mact[i] = 0;
            mnst[i] = mst[i];
            if (cfg_bcast_en && bus.id == cfg_bcast_id) mtgt = 1'b1;
            else mtgt = (cfg_port_id[i*4 +: 4] == bus.id);
            if (mtgt) begin
                if (mv == 0 || mv > IB) begin
                    mact[i] = 2;
                end else if (mst[i] == M_IDLE) begin
                    if (!bus.sop) begin
                        mact[i] = 2;
                    end else begin
                        if (cfg_port_enable[i]) mact[i] = 1;
                        if (!bus.eop)
                            mnst[i] = cfg_port_enable[i] ? M_PKT : M_DROP;
                    end
                end else if (mst[i] == M_PKT) begin
                    if (bus.sop) begin
                        mact[i] = 2;
                    end else begin
                        mact[i] = 1;
                        if (bus.eop) mnst[i] = M_IDLE;
                    end
                end else if (bus.eop) begin
                    mnst[i] = M_IDLE;
                end
            end
            if (mact[i] == 1 && mq[i].size() != 0) mrdy = 1'b0;
        end
        chk("in_ready", bus.in_ready, mrdy);
        if (reset_L) begin
            for (int i = 0; i < P; i++) begin
                if (mq[i].size() != 0) mc = mq[i].pop_front();
                if (bus.val && mrdy) begin
                    mst[i] = mnst[i];
                    if (mact[i] == 1) begin
                        mn = (mv + OB - 1) / OB;
                        for (int k = 0; k < mn; k++) begin
                            mc.d   = OW'(bus.data >> (k * OW));
                            mc.vbc = (mv - k * OB > OB) ? OB : mv - k * OB;
                            mc.sop = bus.sop && (k == 0);
                            mc.eop = bus.eop && (k == mn - 1);
                            mq[i].push_back(mc);
                        end
                    end
                end
                if (cnt_clr[i]) begin
                    mpk[i] = 0;
                    mby[i] = 0;
                    mer[i] = 0;
                end else if (bus.val && mrdy) begin
                    if (mact[i] == 1) begin
                        mby[i] = msat(mby[i] + mv);
                        if (bus.eop) mpk[i] = msat(mpk[i] + 1);
                    end
                    if (mact[i] == 2) mer[i] = msat(mer[i] + 1);
                end
            end
        end
    end

    task automatic send(input logic [3:0] tid, input bit s, input bit e,
                        input int nb, input logic [7:0] seed,
                        output int waited);
        logic [IB*8-1:0] d;
        for (int j = 0; j < IB; j++) d[j*8 +: 8] = seed + 8'(j);
        bus.id   = tid;
        bus.sop  = s;
        bus.eop  = e;
        bus.vbc  = VW'(nb);
        bus.data = d;
        bus.val  = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.val = 1'b0;
        bus.sop = 1'b0;
        bus.eop = 1'b0;
    endtask

    task automatic ssend(input bit clr);
        int w;
        sbus.id  = 4'h0;
        sbus.sop = 1'b1;
        sbus.eop = 1'b1;
        sbus.vbc = 8'd1;
        sbus.val = 1'b1;
        s_clr    = clr;
        w = 0;
        @(negedge clk);
        while (!sbus.in_ready && w < 10) begin
            w++;
            @(negedge clk);
        end
        if (!sbus.in_ready) chk("s_accept_timeout", sbus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        sbus.val = 1'b0;
        s_clr    = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        bus.val = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
        bus.id = 4'h0; bus.vbc = '0; bus.data = '0;
        sbus.val = 1'b0; sbus.sop = 1'b0; sbus.eop = 1'b0;
        sbus.id = 4'h0; sbus.vbc = '0; sbus.data = '0;
        s_clr = 1'b0;
        cfg_port_id     = {4'd3, 4'd2, 4'd1, 4'd0};
        cfg_port_enable = 4'hF;
        cfg_bcast_en    = 1'b1;
        cfg_bcast_id    = 4'hF;
        cnt_clr         = '0;

        #12;
        chk("rst_o_val", o_val, 4'h0);
        chk("rst_ready", ready, 4'hF);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_byte_cnt", byte_cnt, 0);
        @(posedge clk);
        #1 reset_L = 1'b1;
        cyc(1);

        // Unicast: 70 bytes to port 2 -> chunks 32, 32, 6.
        send(4'd2, 1, 1, 70, 8'h10, w);
        chk("uc_wait", w, 0);
        chk("uc_val0", o_val, 4'b0100);
        chk("uc_vbc0", o_vbc[2*OVW +: OVW], 32);
        chk("uc_sop0", o_sop[2], 1'b1);
        chk("uc_eop0", o_eop[2], 1'b0);
        chk("uc_rdy0", ready[2], 1'b0);
        chk("uc_dat0", o_data[2*OW +: 8], 8'h10);
        cyc(1);
        chk("uc_vbc1", o_vbc[2*OVW +: OVW], 32);
        chk("uc_sop1", o_sop[2], 1'b0);
        chk("uc_dat1", o_data[2*OW +: 8], 8'h30);
        cyc(1);
        chk("uc_vbc2", o_vbc[2*OVW +: OVW], 6);
        chk("uc_eop2", o_eop[2], 1'b1);
        chk("uc_rdy2", ready[2], 1'b0);
        chk("uc_dat2", o_data[2*OW +: 8], 8'h50);
        cyc(1);
        chk("uc_val3", o_val[2], 1'b0);
        chk("uc_rdy3", ready[2], 1'b1);
        chk("uc_byte", byte_cnt[2*CW +: CW], 70);
        chk("uc_pkt", pkt_cnt[2*CW +: CW], 1);
        cnt_clr = 4'b0100;
        cyc(1);
        cnt_clr = '0;
        chk("clr_byte2", byte_cnt[2*CW +: CW], 0);

        // Broadcast: full beat to every port, five chunks each.
        send(4'hF, 1, 1, 160, 8'h40, w);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bc_val%0d", k), o_val, 4'hF);
            chk($sformatf("bc_vbc%0d", k), o_vbc, {4{6'd32}});
            cyc(1);
        end
        chk("bc_done", o_val, 4'h0);
        send(4'hF, 1, 1, 160, 8'h80, w);
        send(4'hF, 1, 0, 100, 8'h90, w);
        chk("bc_interval", w, 5);
        send(4'd9, 1, 1, 50, 8'h00, w);
        chk("empty_target_wait", w, 0);
        send(4'hF, 0, 1, 60, 8'h20, w);
        chk("bc_eop_wait", w, 3);
        cyc(4);
        cnt_clr = 4'hF;
        cyc(1);
        cnt_clr = '0;

        // Framing on port 1: sop, sop (dropped), eop.
        send(4'd1, 1, 0, 10, 8'h01, w);
        send(4'd1, 1, 0, 12, 8'h02, w);
        chk("fr_err_wait", w, 0);
        send(4'd1, 0, 1, 20, 8'h03, w);
        cyc(2);
        chk("fr_err1", err_cnt[1*CW +: CW], 1);
        chk("fr_pkt1", pkt_cnt[1*CW +: CW], 1);
        chk("fr_byte1", byte_cnt[1*CW +: CW], 30);
        send(4'd1, 0, 0, 8, 8'h04, w);
        send(4'd1, 1, 1, 40, 8'h05, w);
        cyc(3);
        chk("fr_err2", err_cnt[1*CW +: CW], 2);
        chk("fr_pkt2", pkt_cnt[1*CW +: CW], 2);
        chk("fr_byte2", byte_cnt[1*CW +: CW], 70);

        // Port 3 disabled at sop, re-enabled mid-packet.
        cfg_port_enable = 4'b0111;
        send(4'd3, 1, 0, 50, 8'h11, w);
        chk("dis_wait0", w, 0);
        cfg_port_enable = 4'hF;
        send(4'd3, 0, 0, 50, 8'h12, w);
        chk("dis_wait1", w, 0);
        send(4'd3, 0, 1, 50, 8'h13, w);
        chk("dis_wait2", w, 0);
        chk("dis_val", o_val[3], 1'b0);
        chk("dis_byte", byte_cnt[3*CW +: CW], 0);
        send(4'd3, 1, 1, 50, 8'h14, w);
        chk("en_val", o_val[3], 1'b1);
        cyc(2);
        chk("en_byte", byte_cnt[3*CW +: CW], 50);
        cfg_port_enable = 4'b0111;
        send(4'hF, 1, 1, 40, 8'h15, w);
        chk("bc_dis_val", o_val, 4'b0111);
        cyc(3);
        cfg_port_enable = 4'hF;

        // Reset while port 0 is mid-chunking.
        send(4'd0, 1, 1, 160, 8'h60, w);
        cyc(1);
        #2 reset_L = 1'b0;
        #1;
        chk("rst_mid_val", o_val, 4'h0);
        chk("rst_mid_ready", ready, 4'hF);
        chk("rst_mid_in_ready", bus.in_ready, 1'b1);
        chk("rst_mid_pkt", pkt_cnt, 0);
        @(posedge clk);
        #1 reset_L = 1'b1;
        cyc(4);
        chk("rst_after_val", o_val, 4'h0);

        // Illegal beat sizes.
        send(4'd0, 1, 1, 0, 8'h70, w);
        send(4'd0, 1, 1, 161, 8'h71, w);
        chk("bad_vbc_val", o_val[0], 1'b0);
        chk("bad_vbc_err", err_cnt[0*CW +: CW], 2);
        send(4'd0, 1, 1, 33, 8'h72, w);
        cyc(3);
        chk("good_after_bad", pkt_cnt[0*CW +: CW], 1);

        // Narrow counters saturate; clear beats a coincident accept.
        for (int n = 0; n < 20; n++) ssend(1'b0);
        cyc(2);
        chk("sat_pkt", s_pkt, 4'd15);
        chk("sat_byte", s_byte, 4'd15);
        chk("sat_err", s_err, 4'd0);
        ssend(1'b1);
        chk("clr_val", s_val, 1'b1);
        chk("clr_pkt", s_pkt, 4'd0);
        chk("clr_byte", s_byte, 4'd0);
        cyc(1);
        ssend(1'b0);
        chk("post_clr_pkt", s_pkt, 4'd1);
        chk("post_clr_byte", s_byte, 4'd1);
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/c3po_dispatch.md
C3PO_DISPATCH -- requirements
Module: c3po_dispatch

Interface
REQ-001 SHALL have parameter PORTS_P, default 4: output port count, legal 1..16.
REQ-002 SHALL have parameter IN_BYTES_P, default 160: input beat width in bytes, an integer multiple of OUT_BYTES_P.
REQ-003 SHALL have parameter OUT_BYTES_P, default 32: output chunk width in bytes.
REQ-004 SHALL have parameter CNT_W_P, default 16: statistics counter width.
REQ-005 SHALL use derived widths VW=$clog2(IN_BYTES_P+1) and OVW=$clog2(OUT_BYTES_P+1).
REQ-006 SHALL have a single clock `clk`; reset `reset_L` is asynchronous and active-low.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- reset_L  in  1  asynchronous active-low reset
- val, sop, eop  in  1 each  input beat qualifiers
- id  in  4  destination id
- vbc  in  VW  valid bytes in the beat
- data  in  IN_BYTES_P*8  beat data; byte 0 at the LSBs
- in_ready  out  1  combinational; beat accepted when val&in_ready
- cfg_port_id  in  PORTS_P*4  per-port id
- cfg_port_enable  in  PORTS_P  per-port enable
- cfg_bcast_en  in  1  broadcast enable
- cfg_bcast_id  in  4  broadcast id
- cnt_clr  in  PORTS_P  per-port counter clear pulse
- o_val, o_sop, o_eop  out  PORTS_P each  output chunk qualifiers
- o_vbc  out  PORTS_P*OVW  valid bytes in the chunk
- o_data  out  PORTS_P*OUT_BYTES_P*8  chunk data
- ready  out  PORTS_P  port holding register empty
- pkt_cnt, byte_cnt, err_cnt  out  PORTS_P*CNT_W_P each  per-port statistics

Function
REQ-010 SHALL define the target set as follows: if cfg_bcast_en and id==cfg_bcast_id, all ports; else ports with cfg_port_id[i]==id; an empty set means the beat is discarded with in_ready=1.
REQ-011 SHALL drive in_ready as the AND of ready[i] over targeted ports that are enabled and not dropping; in_ready=1 when no such port exists.
REQ-012 SHALL give each port a framing FSM {IDLE, PKT, DROP}:
- IDLE + sop&eop: stays IDLE.
- IDLE + sop&~eop: to PKT if enabled, else to DROP.
- IDLE without sop: beat dropped, err_cnt++.
REQ-013 SHALL apply these PKT transitions: eop goes to IDLE; a sop beat is dropped, err_cnt++, and the state stays PKT.
REQ-014 SHALL, in DROP, discard beats; eop goes to IDLE; no counters change.
REQ-015 SHALL sample enable only at sop; deasserting enable mid-packet does not truncate the packet.
REQ-016 SHALL treat vbc==0 or vbc>IN_BYTES_P as invalid: beat dropped, err_cnt++, FSM state unchanged.
REQ-017 SHALL, when a beat is accepted into port i, load it into a holding register and set busy[i]; ready[i]=~busy[i] (registered).
REQ-018 SHALL, starting the cycle after acceptance, emit N=ceil(vbc/OUT_BYTES_P) chunks on consecutive cycles, each with o_val=1.
REQ-019 SHALL form chunk k as o_data=data[k*OUT_BYTES_P*8 +: OUT_BYTES_P*8] and o_vbc=min(OUT_BYTES_P, vbc-k*OUT_BYTES_P).
REQ-020 SHALL assert o_sop only on chunk 0 of a sop beat and o_eop only on chunk N-1 of an eop beat.
REQ-021 SHALL clear busy[i] on the cycle chunk N-1 is driven, so ready[i] is 1 the following cycle; the next acceptance is therefore N+1 cycles after the previous one.
REQ-022 SHALL, when o_val=0, hold o_sop=o_eop=0 and o_vbc=0; o_data is don't-care.
REQ-023 SHALL, for a broadcast beat, load all targeted enabled ports in the same cycle; their outputs are cycle-identical.
REQ-024 SHALL update counters on accept: byte_cnt += vbc; pkt_cnt += 1 on an eop beat.
REQ-025 SHALL saturate all counters at 2^CNT_W_P-1 with no wrap.
REQ-026 SHALL let cnt_clr[i] zero all three counters of port i next cycle; clear wins over a simultaneous increment.
REQ-027 SHALL have no downstream backpressure; outputs are never stalled.

Reset
REQ-030 SHALL, while reset_L=0, asynchronously force: FSMs to IDLE, busy=0, ready=all 1s, in_ready=1, all o_* to 0, all counters to 0.
REQ-031 SHALL, on reset mid-chunking, abandon remaining chunks; no partial o_eop is emitted after reset release.

Verification
REQ-040 SHALL cover unicast: cfg_port_id[2]=2, beat id=2, sop=eop=1, vbc=70 at cycle t -> port 2 emits o_vbc 32,32,6 at t+1..t+3 (o_sop at t+1, o_eop at t+3); ready[2]=0 at t+1..t+3 and 1 at t+4; byte_cnt[2]=70, pkt_cnt[2]=1.
REQ-041 SHALL cover broadcast: cfg_bcast_en=1, cfg_bcast_id=F, ports 0..3 enabled, vbc=160 -> every port emits 5 chunks of 32 bytes in identical cycles; in_ready=0 until all ports are ready.
REQ-042 SHALL cover framing: to port 1 send sop-only, sop-only, eop -> second beat dropped, err_cnt[1]=1, pkt_cnt[1]=1, FSM back in IDLE.
REQ-043 SHALL cover disable: cfg_port_enable[3]=0 at sop -> packet fully discarded, no o_val[3], in_ready=1 throughout; re-enable mid-packet -> still dropped until eop.
REQ-044 SHALL cover counters: CNT_W_P=4, 20 single-beat packets -> pkt_cnt=15 (saturated); cnt_clr coincident with an accept -> counters read 0.
REQ-045 SHALL cover reset and illegal vbc: assert reset_L=0 between chunks 2 and 3 -> all o_val=0 and ready=all 1s immediately; vbc=0 and vbc=161 -> each dropped, err_cnt=2.
